// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy patrol controller.
package enemy_pkg;

    typedef enum logic [2:0] {
        ST_DEAD    = 3'd0,
        ST_STILL_L = 3'd1,
        ST_WALK_L  = 3'd2,
        ST_STILL_R = 3'd3,
        ST_WALK_R  = 3'd4,
        ST_SQUASH  = 3'd5
    } enemy_state_t;

    localparam logic [9:0] POS_OFFSCREEN = 10'd700;
    localparam logic [9:0] POS_Y_GROUND  = 10'd432;

endpackage

// File: rtl/enemy_patrol_fsm.sv
// One enemy channel: lifecycle, timed left/right patrol with wall clamp,
// and two-frame walk animation. All outputs come straight from registers.
module enemy_patrol_fsm
    import enemy_pkg::*;
#(
    parameter int unsigned STILL_FRAMES  = 96,
    parameter int unsigned WALK_FRAMES   = 32,
    parameter int unsigned SQUASH_FRAMES = 16,
    parameter int unsigned ANIM_DIV      = 8,
    parameter logic [9:0]  X_MIN         = 10'd3,
    parameter logic [9:0]  X_MAX         = 10'd623,
    parameter logic [9:0]  Y_GROUND      = POS_Y_GROUND,
    parameter logic [9:0]  OFFSCREEN     = POS_OFFSCREEN,
    parameter bit          INIT_ALIVE    = 1'b1,
    parameter logic [9:0]  INIT_X        = 10'd448
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       spawn_i,
    input  logic [9:0] spawn_x_i,
    input  logic       kill_i,
    output logic       alive_o,
    output logic       squashed_o,
    output logic       dir_left_o,
    output logic       walk_frame_o,
    output logic [9:0] pos_x_o,
    output logic [9:0] pos_y_o
);

    localparam int unsigned MAX_SW  = (STILL_FRAMES > WALK_FRAMES) ? STILL_FRAMES : WALK_FRAMES;
    localparam int unsigned MAX_DUR = (MAX_SW > SQUASH_FRAMES) ? MAX_SW : SQUASH_FRAMES;
    localparam int unsigned CNT_W   = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;
    localparam int unsigned ANIM_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic [CNT_W-1:0]  STILL_LAST  = CNT_W'(STILL_FRAMES - 1);
    localparam logic [CNT_W-1:0]  WALK_LAST   = CNT_W'(WALK_FRAMES - 1);
    localparam logic [CNT_W-1:0]  SQUASH_LAST = CNT_W'(SQUASH_FRAMES - 1);
    localparam logic [ANIM_W-1:0] ANIM_LAST   = ANIM_W'(ANIM_DIV - 1);

    enemy_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ANIM_W-1:0] anim_q, anim_d;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic              alive_q, alive_d, squashed_q, squashed_d;
    logic              dir_left_q, dir_left_d, walk_frame_q, walk_frame_d;

    function automatic logic [9:0] clamp_x(input logic [9:0] v);
        if (v < X_MIN) return X_MIN;
        if (v > X_MAX) return X_MAX;
        return v;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= INIT_ALIVE ? ST_STILL_L : ST_DEAD;
            cnt_q        <= '0;
            anim_q       <= '0;
            x_q          <= INIT_ALIVE ? INIT_X : OFFSCREEN;
            y_q          <= INIT_ALIVE ? Y_GROUND : OFFSCREEN;
            alive_q      <= INIT_ALIVE;
            squashed_q   <= 1'b0;
            dir_left_q   <= 1'b1;
            walk_frame_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            anim_q       <= anim_d;
            x_q          <= x_d;
            y_q          <= y_d;
            alive_q      <= alive_d;
            squashed_q   <= squashed_d;
            dir_left_q   <= dir_left_d;
            walk_frame_q <= walk_frame_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        anim_d       = anim_q;
        x_d          = x_q;
        y_d          = y_q;
        alive_d      = alive_q;
        squashed_d   = squashed_q;
        dir_left_d   = dir_left_q;
        walk_frame_d = walk_frame_q;

        case (state_q)
            ST_DEAD: begin
                if (spawn_i) begin
                    state_d      = ST_STILL_L;
                    cnt_d        = '0;
                    anim_d       = '0;
                    walk_frame_d = 1'b0;
                    x_d          = clamp_x(spawn_x_i);
                    y_d          = Y_GROUND;
                    alive_d      = 1'b1;
                end
            end
            ST_SQUASH: begin
                if (tick_i) begin
                    if (cnt_q == SQUASH_LAST) begin
                        state_d      = ST_DEAD;
                        cnt_d        = '0;
                        anim_d       = '0;
                        walk_frame_d = 1'b0;
                        x_d          = OFFSCREEN;
                        y_d          = OFFSCREEN;
                        squashed_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                // Kill pre-empts any patrol progress in the same cycle.
                if (kill_i) begin
                    state_d    = ST_SQUASH;
                    cnt_d      = '0;
                    y_d        = Y_GROUND;
                    alive_d    = 1'b0;
                    squashed_d = 1'b1;
                end else if (tick_i) begin
                    if (anim_q == ANIM_LAST) begin
                        anim_d       = '0;
                        walk_frame_d = ~walk_frame_q;
                    end else begin
                        anim_d = anim_q + 1'b1;
                    end
                    cnt_d = cnt_q + 1'b1;
                    case (state_q)
                        ST_STILL_L: begin
                            if (cnt_q == STILL_LAST) begin
                                state_d    = ST_WALK_L;
                                cnt_d      = '0;
                                dir_left_d = 1'b1;
                            end
                        end
                        ST_WALK_L: begin
                            if (x_q <= X_MIN) begin
                                state_d = ST_STILL_R;
                                cnt_d   = '0;
                            end else begin
                                x_d = x_q - 10'd1;
                                if (cnt_q == WALK_LAST) begin
                                    state_d = ST_STILL_R;
                                    cnt_d   = '0;
                                end
                            end
                        end
                        ST_STILL_R: begin
                            if (cnt_q == STILL_LAST) begin
                                state_d    = ST_WALK_R;
                                cnt_d      = '0;
                                dir_left_d = 1'b0;
                            end
                        end
                        ST_WALK_R: begin
                            if (x_q >= X_MAX) begin
                                state_d = ST_STILL_L;
                                cnt_d   = '0;
                            end else begin
                                x_d = x_q + 10'd1;
                                if (cnt_q == WALK_LAST) begin
                                    state_d = ST_STILL_L;
                                    cnt_d   = '0;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    assign alive_o      = alive_q;
    assign squashed_o   = squashed_q;
    assign dir_left_o   = dir_left_q;
    assign walk_frame_o = walk_frame_q;
    assign pos_x_o      = x_q;
    assign pos_y_o      = y_q;

endmodule

// File: rtl/enemy_patrol_array.sv
// N independent enemy channels; packs per-channel state onto flat buses
// for the game logic and sprite renderer.
module enemy_patrol_array
    import enemy_pkg::*;
#(
    parameter int unsigned          N_ENEMY       = 4,
    parameter int unsigned          STILL_FRAMES  = 96,
    parameter int unsigned          WALK_FRAMES   = 32,
    parameter int unsigned          SQUASH_FRAMES = 16,
    parameter int unsigned          ANIM_DIV      = 8,
    parameter logic [9:0]           X_MIN         = 10'd3,
    parameter logic [9:0]           X_MAX         = 10'd623,
    parameter logic [9:0]           Y_GROUND      = POS_Y_GROUND,
    parameter logic [9:0]           OFFSCREEN     = POS_OFFSCREEN,
    parameter logic [N_ENEMY-1:0]   INIT_ALIVE    = N_ENEMY'(1),
    parameter logic [10*N_ENEMY-1:0] INIT_X       = {N_ENEMY{10'd448}}
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_tick,
    input  logic [N_ENEMY-1:0]      spawn,
    input  logic [10*N_ENEMY-1:0]   spawn_x,
    input  logic [N_ENEMY-1:0]      kill,
    output logic [N_ENEMY-1:0]      alive,
    output logic [N_ENEMY-1:0]      squashed,
    output logic [N_ENEMY-1:0]      dir_left,
    output logic [N_ENEMY-1:0]      walk_frame,
    output logic [10*N_ENEMY-1:0]   pos_x,
    output logic [10*N_ENEMY-1:0]   pos_y
);

    for (genvar i = 0; i < N_ENEMY; i++) begin : g_enemy
        enemy_patrol_fsm #(
            .STILL_FRAMES (STILL_FRAMES),
            .WALK_FRAMES  (WALK_FRAMES),
            .SQUASH_FRAMES(SQUASH_FRAMES),
            .ANIM_DIV     (ANIM_DIV),
            .X_MIN        (X_MIN),
            .X_MAX        (X_MAX),
            .Y_GROUND     (Y_GROUND),
            .OFFSCREEN    (OFFSCREEN),
            .INIT_ALIVE   (INIT_ALIVE[i]),
            .INIT_X       (INIT_X[10*i +: 10])
        ) u_fsm (
            .clk_i       (Clk),
            .rst_i       (Reset),
            .tick_i      (frame_tick),
            .spawn_i     (spawn[i]),
            .spawn_x_i   (spawn_x[10*i +: 10]),
            .kill_i      (kill[i]),
            .alive_o     (alive[i]),
            .squashed_o  (squashed[i]),
            .dir_left_o  (dir_left[i]),
            .walk_frame_o(walk_frame[i]),
            .pos_x_o     (pos_x[10*i +: 10]),
            .pos_y_o     (pos_y[10*i +: 10])
        );
    end

endmodule
